// File: rtl/tcam_pkg.sv
// Shared types and helpers for the TCAM lookup arbiter and its round-robin arbiter.
package tcam_pkg;

   localparam int unsigned KEY_W_DEF   = 128;
   localparam int unsigned ENTRIES_DEF = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WR_VAL = 2'd1,
      WR_MSK = 2'd2
   } state_t;

   // Index width that never collapses to zero for a single-element space.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned w;
      w = $clog2(n);
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the last granted requester.
module rr_arbiter
   import tcam_pkg::*;
#(
   parameter int unsigned N    = 4,
   parameter int unsigned ID_W = clog2_min1(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [N-1:0]    req,
   input  logic            advance,
   output logic [N-1:0]    grant,
   output logic [ID_W-1:0] grant_id,
   output logic            grant_valid
);

   logic [ID_W-1:0] ptr;
   int unsigned     idx;

   // Search ptr+1 .. ptr+N modulo N; the first asserted request wins.
   always_comb begin
      grant       = '0;
      grant_id    = '0;
      grant_valid = 1'b0;
      idx         = 0;
      for (int unsigned i = 1; i <= N; i++) begin
         idx = (32'(ptr) + i) % N;
         if (en && !grant_valid && req[idx[ID_W-1:0]]) begin
            grant[idx[ID_W-1:0]] = 1'b1;
            grant_id             = idx[ID_W-1:0];
            grant_valid          = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= ID_W'(N - 1);
      end else if (advance && grant_valid) begin
         ptr <= grant_id;
      end
   end

endmodule

// File: rtl/tcam_lookup_arb.sv
// Shares one TCAM port between NREQ lookup requesters and an atomic value+mask rule writer.
// Optional counters enabled by TCAM_LOOKUP_ARB_STATS_EN.
module tcam_lookup_arb
   import tcam_pkg::*;
#(
   parameter int unsigned KEY_W   = KEY_W_DEF,
   parameter int unsigned ENTRIES = ENTRIES_DEF,
   parameter int unsigned NREQ    = 4,
   localparam int unsigned IDX_W  = $clog2(ENTRIES),
   localparam int unsigned ID_W   = clog2_min1(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef TCAM_LOOKUP_ARB_STATS_EN
   input  logic                  stat_clr,
   output logic [31:0]           stat_lookups,
   output logic [31:0]           stat_hits,
`endif
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*KEY_W-1:0] req_key,
   output logic [NREQ-1:0]       req_ready,
   output logic                  resp_valid,
   output logic [ID_W-1:0]       resp_id,
   output logic                  resp_hit,
   output logic [IDX_W-1:0]      resp_index,
   input  logic                  cfg_valid,
   input  logic [IDX_W-1:0]      cfg_addr,
   input  logic [KEY_W-1:0]      cfg_value,
   input  logic [KEY_W-1:0]      cfg_mask,
   output logic                  cfg_ready,
   output logic [KEY_W-1:0]      tcam_key,
   output logic                  tcam_key_valid,
   output logic                  tcam_wr_en,
   output logic                  tcam_wr_is_mask,
   output logic [IDX_W-1:0]      tcam_wr_addr,
   output logic [KEY_W-1:0]      tcam_wr_data,
   input  logic                  tcam_hit,
   input  logic [IDX_W-1:0]      tcam_hit_index
);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] stg_addr;
   logic [KEY_W-1:0] stg_value, stg_mask;
   logic             lookup_en;
   logic [ID_W-1:0]  grant_id;
   logic             grant_valid;

   rr_arbiter #(
      .N    (NREQ),
      .ID_W (ID_W)
   ) u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (lookup_en),
      .req         (req_valid),
      .advance     (1'b1),
      .grant       (req_ready),
      .grant_id    (grant_id),
      .grant_valid (grant_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Rule writes pre-empt lookups; the TCAM port is held for the whole value+mask pair.
   always_comb begin
      state_nxt       = state;
      cfg_ready       = 1'b0;
      lookup_en       = 1'b0;
      tcam_wr_en      = 1'b0;
      tcam_wr_is_mask = 1'b0;
      tcam_wr_addr    = '0;
      tcam_wr_data    = '0;
      case (state)
         IDLE: begin
            cfg_ready = rst_n && cfg_valid;
            lookup_en = rst_n && !cfg_valid;
            if (cfg_valid) begin
               state_nxt = WR_VAL;
            end
         end
         WR_VAL: begin
            tcam_wr_en   = 1'b1;
            tcam_wr_addr = stg_addr;
            tcam_wr_data = stg_value;
            state_nxt    = WR_MSK;
         end
         WR_MSK: begin
            tcam_wr_en      = 1'b1;
            tcam_wr_is_mask = 1'b1;
            tcam_wr_addr    = stg_addr;
            tcam_wr_data    = stg_mask;
            state_nxt       = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_addr  <= '0;
         stg_value <= '0;
         stg_mask  <= '0;
      end else if (state == IDLE && cfg_valid) begin
         stg_addr  <= cfg_addr;
         stg_value <= cfg_value;
         stg_mask  <= cfg_mask;
      end
   end

   always_comb begin
      tcam_key_valid = grant_valid;
      tcam_key       = '0;
      if (grant_valid) begin
         tcam_key = req_key[32'(grant_id)*KEY_W +: KEY_W];
      end
   end

   // Response fields hold their last values between lookups.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_hit   <= 1'b0;
         resp_index <= '0;
      end else begin
         resp_valid <= grant_valid;
         if (grant_valid) begin
            resp_id    <= grant_id;
            resp_hit   <= tcam_hit;
            resp_index <= tcam_hit_index;
         end
      end
   end

`ifdef TCAM_LOOKUP_ARB_STATS_EN
   // Saturating counters; clear wins over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_lookups <= '0;
         stat_hits    <= '0;
      end else if (stat_clr) begin
         stat_lookups <= '0;
         stat_hits    <= '0;
      end else if (resp_valid) begin
         if (stat_lookups != 32'hFFFF_FFFF) begin
            stat_lookups <= stat_lookups + 32'd1;
         end
         if (resp_hit && stat_hits != 32'hFFFF_FFFF) begin
            stat_hits <= stat_hits + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_tcam_lookup_arb.sv
// Directed bench for tcam_lookup_arb with a behavioural 16-entry TCAM on the lookup/write port.
// Counter checks are compiled in with TCAM_LOOKUP_ARB_STATS_EN.
module tb_tcam_lookup_arb;

   localparam int unsigned KEY_W   = 128;
   localparam int unsigned ENTRIES = 16;
   localparam int unsigned NREQ    = 4;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned ID_W    = 2;

   logic                  clk;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*KEY_W-1:0] req_key;
   logic [NREQ-1:0]       req_ready;
   logic                  resp_valid;
   logic [ID_W-1:0]       resp_id;
   logic                  resp_hit;
   logic [IDX_W-1:0]      resp_index;
   logic                  cfg_valid;
   logic [IDX_W-1:0]      cfg_addr;
   logic [KEY_W-1:0]      cfg_value;
   logic [KEY_W-1:0]      cfg_mask;
   logic                  cfg_ready;
   logic [KEY_W-1:0]      tcam_key;
   logic                  tcam_key_valid;
   logic                  tcam_wr_en;
   logic                  tcam_wr_is_mask;
   logic [IDX_W-1:0]      tcam_wr_addr;
   logic [KEY_W-1:0]      tcam_wr_data;
   logic                  tcam_hit;
   logic [IDX_W-1:0]      tcam_hit_index;
`ifdef TCAM_LOOKUP_ARB_STATS_EN
   logic                  stat_clr;
   logic [31:0]           stat_lookups;
   logic [31:0]           stat_hits;
`endif

   logic [KEY_W-1:0] tv [ENTRIES];
   logic [KEY_W-1:0] tm [ENTRIES];
   logic             load_init;
   int               n_assert;
   int               n_fail;

   tcam_lookup_arb #(
      .KEY_W   (KEY_W),
      .ENTRIES (ENTRIES),
      .NREQ    (NREQ)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
`ifdef TCAM_LOOKUP_ARB_STATS_EN
      .stat_clr        (stat_clr),
      .stat_lookups    (stat_lookups),
      .stat_hits       (stat_hits),
`endif
      .req_valid       (req_valid),
      .req_key         (req_key),
      .req_ready       (req_ready),
      .resp_valid      (resp_valid),
      .resp_id         (resp_id),
      .resp_hit        (resp_hit),
      .resp_index      (resp_index),
      .cfg_valid       (cfg_valid),
      .cfg_addr        (cfg_addr),
      .cfg_value       (cfg_value),
      .cfg_mask        (cfg_mask),
      .cfg_ready       (cfg_ready),
      .tcam_key        (tcam_key),
      .tcam_key_valid  (tcam_key_valid),
      .tcam_wr_en      (tcam_wr_en),
      .tcam_wr_is_mask (tcam_wr_is_mask),
      .tcam_wr_addr    (tcam_wr_addr),
      .tcam_wr_data    (tcam_wr_data),
      .tcam_hit        (tcam_hit),
      .tcam_hit_index  (tcam_hit_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural TCAM: entry 2 = 0x10, entry 3 = 0xAB, others unreachable by the keys used here.
   always @(posedge clk) begin
      if (load_init) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            tv[i] <= 128'hDEAD_0000 + 128'(i);
            tm[i] <= '0;
         end
         tv[2] <= 128'h10;
         tv[3] <= 128'hAB;
      end else if (tcam_wr_en) begin
         if (tcam_wr_is_mask) tm[tcam_wr_addr] <= tcam_wr_data;
         else                 tv[tcam_wr_addr] <= tcam_wr_data;
      end
   end

   always_comb begin
      tcam_hit       = 1'b0;
      tcam_hit_index = '0;
      for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
         if (((tcam_key ^ tv[i]) & ~tm[i]) == '0) begin
            tcam_hit       = 1'b1;
            tcam_hit_index = IDX_W'(i);
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_assert  = 0;
      n_fail    = 0;
      load_init = 1'b1;
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      req_key   = '0;
      cfg_valid = 1'b0;
      cfg_addr  = '0;
      cfg_value = '0;
      cfg_mask  = '0;
`ifdef TCAM_LOOKUP_ARB_STATS_EN
      stat_clr  = 1'b0;
`endif

      // Reset values, with requests already pending
      @(negedge clk);
      load_init = 1'b0;
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_id", resp_id, 0);
      chk("rst_resp_hit", resp_hit, 0);
      chk("rst_resp_index", resp_index, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_cfg_ready", cfg_ready, 0);
      chk("rst_wr_en", tcam_wr_en, 0);
      chk("rst_key_valid", tcam_key_valid, 0);
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // Single lookup hitting entry 3
      @(negedge clk);
      req_valid = 4'b0001;
      req_key[0 +: KEY_W] = 128'hAB;
      #1;
      chk("t1_req_ready", req_ready, 4'b0001);
      chk("t1_tcam_key", tcam_key, 128'hAB);
      chk("t1_key_valid", tcam_key_valid, 1);
      @(negedge clk);
      chk("t1_resp_valid", resp_valid, 1);
      chk("t1_resp_id", resp_id, 0);
      chk("t1_resp_hit", resp_hit, 1);
      chk("t1_resp_index", resp_index, 3);
      req_valid = '0;
      #1;
      chk("t1_idle_ready", req_ready, 0);
      chk("t1_idle_key", tcam_key, 0);
      @(negedge clk);
      chk("t1_resp_drop", resp_valid, 0);
      chk("t1_hold_hit", resp_hit, 1);
      chk("t1_hold_index", resp_index, 3);

      // Round-robin with all four requesting; last grant was 0
      for (int r = 0; r < int'(NREQ); r++) req_key[r*KEY_W +: KEY_W] = 128'h100 + 128'(r);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         req_valid = 4'b1111;
         if (c > 0) chk("rr_resp_id", resp_id, 128'(c % 4));
         #1;
         chk("rr_grant", req_ready, 128'(4'b0001 << ((c + 1) % 4)));
      end
      @(negedge clk);
      chk("rr_last_resp_id", resp_id, 0);
      chk("rr_last_miss", resp_hit, 0);
      req_valid = '0;

      // Rule write pre-empts a lookup; entry 5 = 0x55 with upper nibble of byte don't-care
      @(negedge clk);
      req_valid = 4'b0010;
      req_key[1*KEY_W +: KEY_W] = 128'h35;
      cfg_valid = 1'b1;
      cfg_addr  = 4'd5;
      cfg_value = 128'h55;
      cfg_mask  = 128'hF0;
      #1;
      chk("t3_cfg_ready", cfg_ready, 1);
      chk("t3_req_ready", req_ready, 0);
      chk("t3_wr_en_idle", tcam_wr_en, 0);
      chk("t3_key_valid", tcam_key_valid, 0);
      @(negedge clk);
      cfg_valid = 1'b0;
      #1;
      chk("t3_val_wr_en", tcam_wr_en, 1);
      chk("t3_val_is_mask", tcam_wr_is_mask, 0);
      chk("t3_val_addr", tcam_wr_addr, 5);
      chk("t3_val_data", tcam_wr_data, 128'h55);
      chk("t3_val_req_ready", req_ready, 0);
      chk("t3_val_cfg_ready", cfg_ready, 0);
      chk("t3_val_resp_valid", resp_valid, 0);
      @(negedge clk);
      #1;
      chk("t3_msk_wr_en", tcam_wr_en, 1);
      chk("t3_msk_is_mask", tcam_wr_is_mask, 1);
      chk("t3_msk_addr", tcam_wr_addr, 5);
      chk("t3_msk_data", tcam_wr_data, 128'hF0);
      chk("t3_msk_req_ready", req_ready, 0);
      @(negedge clk);
      #1;
      chk("t3_after_grant", req_ready, 4'b0010);
      chk("t3_after_wr_en", tcam_wr_en, 0);
      chk("t3_after_wr_addr", tcam_wr_addr, 0);
      chk("t3_after_wr_data", tcam_wr_data, 0);
      @(negedge clk);
      chk("t3_resp_id", resp_id, 1);
      chk("t3_resp_hit", resp_hit, 1);
      chk("t3_resp_index", resp_index, 5);
      req_valid = '0;

      // Atomic rewrite of entry 2 from 0x10 to 0x20 under a continuous 0x20 lookup
      @(negedge clk);
      req_valid = 4'b0001;
      req_key[0 +: KEY_W] = 128'h20;
      #1;
      chk("t4_pre_grant", req_ready, 4'b0001);
      @(negedge clk);
      chk("t4_pre_resp_valid", resp_valid, 1);
      chk("t4_pre_resp_hit", resp_hit, 0);
      cfg_valid = 1'b1;
      cfg_addr  = 4'd2;
      cfg_value = 128'h20;
      cfg_mask  = '0;
      #1;
      chk("t4_cfg_ready", cfg_ready, 1);
      chk("t4_cfg_req_ready", req_ready, 0);
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("t4_val_resp_valid", resp_valid, 0);
      #1;
      chk("t4_val_req_ready", req_ready, 0);
      chk("t4_val_data", tcam_wr_data, 128'h20);
      @(negedge clk);
      chk("t4_msk_resp_valid", resp_valid, 0);
      #1;
      chk("t4_msk_req_ready", req_ready, 0);
      @(negedge clk);
      #1;
      chk("t4_post_grant", req_ready, 4'b0001);
      @(negedge clk);
      chk("t4_post_resp_valid", resp_valid, 1);
      chk("t4_post_hit", resp_hit, 1);
      chk("t4_post_index", resp_index, 2);
      req_valid = '0;

      // Reset asserted in WR_VAL
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_addr  = 4'd7;
      cfg_value = 128'h77;
      @(negedge clk);
      cfg_valid = 1'b0;
      req_valid = 4'b1111;
      #1;
      chk("t5_in_wr_val", tcam_wr_en, 1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_wr_en", tcam_wr_en, 0);
      chk("t5_rst_req_ready", req_ready, 0);
      chk("t5_rst_cfg_ready", cfg_ready, 0);
      chk("t5_rst_key_valid", tcam_key_valid, 0);
      chk("t5_rst_resp_valid", resp_valid, 0);
      chk("t5_rst_resp_hit", resp_hit, 0);
      chk("t5_rst_resp_index", resp_index, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("t5_first_grant", req_ready, 4'b0001);
      chk("t5_first_wr_en", tcam_wr_en, 0);
      @(negedge clk);
      chk("t5_first_resp_id", resp_id, 0);
      req_valid = '0;

`ifdef TCAM_LOOKUP_ARB_STATS_EN
      // Counters: 10 lookups of which the first 6 hit entry 3
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      chk("st_clr_lookups", stat_lookups, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         req_valid = 4'b0001;
         req_key[0 +: KEY_W] = (i < 6) ? 128'hAB : 128'h999;
      end
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      chk("st_lookups", stat_lookups, 10);
      chk("st_hits", stat_hits, 6);
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      chk("st_clr2_lookups", stat_lookups, 0);
      chk("st_clr2_hits", stat_hits, 0);
`endif

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/tcam_lookup_arb.md
Name: tcam_lookup_arb

Overview:
- Shares one combinational TCAM lookup/write port between NREQ datapath lookup requesters and one control-plane rule-write port.
- Round-robin arbitration among lookup requesters; registered response tagged with requester ID.
- Atomic two-cycle rule installs (value, then mask) with lookups blocked, so no lookup sees a half-written entry.
- Sits between parser/classifier clients and tcam_ctrl.

Parameters:
- KEY_W, 128, key/value/mask width
- ENTRIES, 16, TCAM entries; IDX_W = $clog2(ENTRIES)
- NREQ, 4, lookup requesters; ID_W = $clog2(NREQ), min 1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester lookup request
- req_key  in  NREQ*KEY_W  requester r key at bits [r*KEY_W +: KEY_W]
- req_ready  out  NREQ  one-hot grant, combinational
- resp_valid  out  1  lookup result valid, one-cycle pulse
- resp_id  out  ID_W  requester that owns the result
- resp_hit  out  1  TCAM hit
- resp_index  out  IDX_W  lowest matching index
- cfg_valid  in  1  rule-write request
- cfg_addr  in  IDX_W  entry to write
- cfg_value  in  KEY_W  entry value
- cfg_mask  in  KEY_W  entry mask (1 = don't care)
- cfg_ready  out  1  rule write accepted this cycle
- tcam_key  out  KEY_W  key to TCAM
- tcam_key_valid  out  1  lookup qualifier to TCAM
- tcam_wr_en  out  1  TCAM write strobe
- tcam_wr_is_mask  out  1  0 = value write, 1 = mask write
- tcam_wr_addr  out  IDX_W  TCAM write address
- tcam_wr_data  out  KEY_W  TCAM write data
- tcam_hit  in  1  TCAM hit (combinational from tcam_key)
- tcam_hit_index  in  IDX_W  TCAM hit index

Behaviour:
- Reset values:
  - resp_valid=0, resp_id=0, resp_hit=0, resp_index=0.
  - State=IDLE, rr_ptr=NREQ-1, staged cfg registers=0.
  - Combinational outputs at reset: req_ready=0, cfg_ready=0, tcam_wr_en=0, tcam_key_valid=0.
- States:
  - IDLE: lookups allowed.
  - WR_VAL: tcam_wr_en=1, tcam_wr_is_mask=0, data=staged value.
  - WR_MSK: tcam_wr_en=1, tcam_wr_is_mask=1, data=staged mask.
- Transitions:
  - IDLE->WR_VAL when cfg_valid; cfg_ready=1 that cycle; stage addr/value/mask.
  - WR_VAL->WR_MSK unconditionally.
  - WR_MSK->IDLE unconditionally.
  - cfg_ready=0 outside IDLE.
- Priority: cfg_valid in IDLE wins over lookups; req_ready=0 that cycle and during WR_VAL/WR_MSK. Lookups are therefore blocked for 3 cycles per rule write.
- Arbitration:
  - In IDLE with no cfg_valid, grant the first asserted req_valid searching rr_ptr+1, rr_ptr+2, … modulo NREQ.
  - req_ready is one-hot or zero.
  - rr_ptr <= granted ID on grant only.
- Lookup handshake and latency:
  - Transfer occurs when req_valid[r] && req_ready[r].
  - In the grant cycle, tcam_key=req_key[r] and tcam_key_valid=1; tcam_hit/tcam_hit_index are sampled at that edge.
  - Next cycle: resp_valid=1 with resp_id=r, resp_hit, resp_index.
  - Latency 1 cycle; throughput 1 lookup/cycle; no response backpressure.
  - When no grant: resp_valid=0; resp_id/resp_hit/resp_index hold their last values.
- tcam_key: 0 when no grant. tcam_wr_addr/tcam_wr_data: 0 in IDLE.
- Requesters may hold req_valid across cycles; key must stay stable until granted.
- Boundary conditions:
  - Back-to-back cfg: second accepted on the first IDLE cycle after WR_MSK.
  - A lookup granted in the cycle before WR_VAL sees old entry contents; the first lookup after WR_MSK sees the new entry.
  - NREQ=1: always grant req 0 when allowed.
  - Reset mid-write: state returns to IDLE; TCAM entry may be partial and software must rewrite it.

Optional Feature:
- Macro: TCAM_LOOKUP_ARB_STATS_EN.
- With macro: add outputs stat_lookups (32) and stat_hits (32).
  - stat_lookups increments on each resp_valid.
  - stat_hits increments on resp_valid && resp_hit.
  - Both saturate at 32'hFFFF_FFFF; reset to 0.
  - Add input stat_clr (1): synchronous clear, takes priority over increment.
- Without macro: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package tcam_pkg:
  - state enum {IDLE, WR_VAL, WR_MSK};
  - default KEY_W and ENTRIES localparams;
  - function clog2_min1.
- One sub-module: rr_arbiter (NREQ req in, one-hot grant out, ptr register, advance-on-grant input), reusable by other shared datapath resources.

Test Plan:
- Single lookup: req_valid=4'b0001, key=0xAB, TCAM entry 3 value=0xAB mask=0 -> req_ready=0001 that cycle; next cycle resp_valid=1, id=0, hit=1, index=3.
- Round-robin: req_valid=4'b1111 held for 8 cycles -> grants 0,1,2,3,0,1,2,3; resp_id follows one cycle later.
- Cfg priority: cfg_valid with req_valid=4'b0010 in same cycle -> cfg_ready=1, req_ready=0; WR_VAL (is_mask=0) then WR_MSK (is_mask=1) on cfg_addr=5; req 1 granted in the cycle after WR_MSK.
- Atomic install: rewrite entry 2 from value 0x10 to 0x20 while key=0x20 requested continuously -> every response hits index 2 only after install, never a partial match; no grant in the three write cycles.
- Reset: assert rst_n=0 during WR_VAL -> all outputs at reset values asynchronously; after release, the next grant goes to requester 0.
- Stats (macro on): 10 lookups, 6 hits -> stat_lookups=10, stat_hits=6; stat_clr -> 0; preloaded 0xFFFF_FFFF does not wrap.
